// File: rtl/fetch_unit_if.sv
// Instruction memory read port: request/grant address phase, rvalid data phase.
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_gnt;
    logic             imem_rvalid;
    logic [WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one read outstanding, buffers one
// instruction for decode and redirects/flushes on a taken branch or jump.
module fetch_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h00000013)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pcbranch,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             stall,
    fetch_unit_if.master     imem,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc,
    output logic             instr_valid
);

    typedef enum logic {
        S_REQ,
        S_WAIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] fetch_pc_next;
    logic [WIDTH-1:0] req_pc;
    logic [WIDTH-1:0] req_pc_next;
    logic             kill;
    logic             kill_next;
    logic             req;
    logic             fire;
    logic             deliver;
    logic [WIDTH-1:0] target_aligned;

    assign target_aligned = branch_target & ~{{(WIDTH-2){1'b0}}, 2'b11};

    // A pending kill also blocks issue, so a stale response can never be
    // mistaken for the answer to a fresh request.
    always_comb begin
        req = rst_n && (state == S_REQ) && !kill && (!instr_valid || !stall);
        imem.imem_req  = req;
        imem.imem_addr = fetch_pc;
        fire    = req && imem.imem_gnt;
        deliver = (state == S_WAIT) && imem.imem_rvalid && !kill && !pcbranch;
    end

    always_comb begin
        state_next    = state;
        kill_next     = kill;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;

        case (state)
            S_REQ: begin
                if (kill && imem.imem_rvalid) begin
                    kill_next = 1'b0;
                end
                if (fire) begin
                    req_pc_next = fetch_pc;
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    state_next = S_REQ;
                    if (kill) begin
                        kill_next = 1'b0;
                    end else begin
                        fetch_pc_next = req_pc + WIDTH'(4);
                    end
                end
            end
            default: state_next = S_REQ;
        endcase

        // Redirect wins over everything; a request still in flight gets killed.
        if (pcbranch) begin
            fetch_pc_next = target_aligned;
            if ((state == S_WAIT) && !imem.imem_rvalid) begin
                kill_next  = 1'b1;
                state_next = S_WAIT;
            end else if ((state == S_REQ) && fire) begin
                kill_next  = 1'b1;
                state_next = S_WAIT;
            end else if (state == S_WAIT) begin
                kill_next  = 1'b0;
                state_next = S_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_REQ;
            fetch_pc    <= RESET_PC;
            req_pc      <= RESET_PC;
            kill        <= (kill || (state == S_WAIT)) && !imem.imem_rvalid;
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            pc          <= RESET_PC;
        end else begin
            state    <= state_next;
            kill     <= kill_next;
            fetch_pc <= fetch_pc_next;
            req_pc   <= req_pc_next;
            if (pcbranch) begin
                instr_valid <= 1'b0;
                instr       <= NOP_INSTR;
            end else if (deliver) begin
                instr_valid <= 1'b1;
                instr       <= imem.imem_rdata;
                pc          <= req_pc;
            end else if (!stall) begin
                instr_valid <= 1'b0;
                instr       <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// scored against a program-order model of the expected instruction stream.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h00000000;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcbranch;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;

    int checks = 0;
    int errors = 0;

    fetch_unit_if #(.WIDTH(32)) bus ();

    fetch_unit #(
        .WIDTH(32),
        .RESET_PC(RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pcbranch(pcbranch),
        .branch_target(branch_target),
        .stall(stall),
        .imem(bus),
        .instr(instr),
        .pc(pc),
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        pcbranch         = 1'b0;
        branch_target    = '0;
        stall            = 1'b0;
        bus.imem_gnt     = 1'b0;
        bus.imem_rvalid  = 1'b0;
        bus.imem_rdata   = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) begin
            tick();
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
            checks++; if (instr !== NOP) begin errors++; $display("[TB] FAIL reset_instr: got %h expected %h", instr, NOP); end
            checks++; if (pc !== RESET_PC) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, RESET_PC); end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", bus.imem_req); end
        end
    endtask

    task automatic test_basic();
        rst_n = 1'b1;
        bus.imem_gnt = 1'b1;
        settle();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL basic_req0: got req=%b addr=%h expected req=1 addr=00000000", bus.imem_req, bus.imem_addr); end
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h00500093;
        settle();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL basic_wait_req: got %b expected 0", bus.imem_req); end
        tick();
        checks++; if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h00500093) begin errors++; $display("[TB] FAIL basic_first: got v=%b pc=%h instr=%h expected v=1 pc=00000000 instr=00500093", instr_valid, pc, instr); end
        bus.imem_rvalid = 1'b0;
        bus.imem_gnt    = 1'b1;
        settle();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL basic_req4: got req=%b addr=%h expected req=1 addr=00000004", bus.imem_req, bus.imem_addr); end
        tick();
        checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("[TB] FAIL basic_drain: got v=%b instr=%h expected v=0 instr=%h", instr_valid, instr, NOP); end
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h00A00113;
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        checks++; if (instr_valid !== 1'b1 || pc !== 32'h4 || instr !== 32'h00A00113) begin errors++; $display("[TB] FAIL basic_second: got v=%b pc=%h instr=%h expected v=1 pc=00000004 instr=00a00113", instr_valid, pc, instr); end
        checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL basic_addr8: got %h expected 00000008", bus.imem_addr); end
    endtask

    task automatic test_stall();
        stall        = 1'b1;
        bus.imem_gnt = 1'b1;
        settle();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req: got %b expected 0", bus.imem_req); end
        repeat (5) begin
            tick();
            checks++; if (instr_valid !== 1'b1 || pc !== 32'h4 || instr !== 32'h00A00113) begin errors++; $display("[TB] FAIL stall_hold: got v=%b pc=%h instr=%h expected v=1 pc=00000004 instr=00a00113", instr_valid, pc, instr); end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_hold: got %b expected 0", bus.imem_req); end
        end
        stall = 1'b0;
        settle();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL stall_release: got req=%b addr=%h expected req=1 addr=00000008", bus.imem_req, bus.imem_addr); end
        tick();
        bus.imem_gnt = 1'b0;
    endtask

    task automatic test_redirect_wait();
        pcbranch      = 1'b1;
        branch_target = 32'h00000123;
        tick();
        checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("[TB] FAIL redir_wait_flush: got v=%b instr=%h expected v=0 instr=%h", instr_valid, instr, NOP); end
        pcbranch        = 1'b0;
        branch_target   = '0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEADBEEF;
        tick();
        checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("[TB] FAIL redir_wait_stale: got v=%b instr=%h expected v=0 instr=%h", instr_valid, instr, NOP); end
        bus.imem_rvalid = 1'b0;
        bus.imem_gnt    = 1'b1;
        settle();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h00000120) begin errors++; $display("[TB] FAIL redir_wait_addr: got req=%b addr=%h expected req=1 addr=00000120", bus.imem_req, bus.imem_addr); end
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h00100073;
        tick();
        bus.imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1 || pc !== 32'h00000120 || instr !== 32'h00100073) begin errors++; $display("[TB] FAIL redir_wait_deliver: got v=%b pc=%h instr=%h expected v=1 pc=00000120 instr=00100073", instr_valid, pc, instr); end
    endtask

    task automatic test_redirect_rvalid();
        bus.imem_gnt = 1'b1;
        settle();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h00000124) begin errors++; $display("[TB] FAIL redir_rv_addr124: got req=%b addr=%h expected req=1 addr=00000124", bus.imem_req, bus.imem_addr); end
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEADBEEF;
        pcbranch        = 1'b1;
        branch_target   = 32'h00000200;
        tick();
        checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("[TB] FAIL redir_rv_drop: got v=%b instr=%h expected v=0 instr=%h", instr_valid, instr, NOP); end
        pcbranch        = 1'b0;
        bus.imem_rvalid = 1'b0;
        settle();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h00000200) begin errors++; $display("[TB] FAIL redir_rv_target: got req=%b addr=%h expected req=1 addr=00000200", bus.imem_req, bus.imem_addr); end
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h00208033;
        tick();
        bus.imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1 || pc !== 32'h00000200 || instr !== 32'h00208033) begin errors++; $display("[TB] FAIL redir_rv_deliver: got v=%b pc=%h instr=%h expected v=1 pc=00000200 instr=00208033", instr_valid, pc, instr); end
    endtask

    task automatic test_wrap();
        pcbranch      = 1'b1;
        branch_target = 32'hFFFFFFFF;
        tick();
        pcbranch = 1'b0;
        settle();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL wrap_align: got req=%b addr=%h expected req=1 addr=fffffffc", bus.imem_req, bus.imem_addr); end
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h00000517;
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        checks++; if (instr_valid !== 1'b1 || pc !== 32'hFFFFFFFC || instr !== 32'h00000517) begin errors++; $display("[TB] FAIL wrap_deliver: got v=%b pc=%h instr=%h expected v=1 pc=fffffffc instr=00000517", instr_valid, pc, instr); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next: got req=%b addr=%h expected req=1 addr=00000000", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_reset_wait();
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
        rst_n        = 1'b0;
        settle();
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstw_req_during: got %b expected 0", bus.imem_req); end
        repeat (2) begin
            tick();
            checks++; if (instr_valid !== 1'b0 || instr !== NOP || pc !== RESET_PC || bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstw_outputs: got v=%b instr=%h pc=%h req=%b expected v=0 instr=%h pc=%h req=0", instr_valid, instr, pc, bus.imem_req, NOP, RESET_PC); end
        end
        rst_n           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEADBEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || instr !== NOP) begin errors++; $display("[TB] FAIL rstw_stale: got v=%b instr=%h expected v=0 instr=%h", instr_valid, instr, NOP); end
        bus.imem_gnt = 1'b1;
        settle();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin errors++; $display("[TB] FAIL rstw_refetch: got req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, RESET_PC); end
        tick();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h00300193;
        tick();
        bus.imem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1 || pc !== RESET_PC || instr !== 32'h00300193) begin errors++; $display("[TB] FAIL rstw_deliver: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=00300193", instr_valid, pc, instr, RESET_PC); end
    endtask

    // The model only knows program order: each new instruction is the one after
    // the previous, or the aligned target of the last redirect.
    task automatic test_random();
        logic        pending;
        logic [31:0] pend_addr;
        int          countdown;
        logic [31:0] exp_next;
        logic        held_prev;
        logic        redirect_prev;
        logic [31:0] prev_instr;
        logic [31:0] prev_pc;
        int          last_delivery;

        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n         = 1'b1;
        pending       = 1'b0;
        pend_addr     = '0;
        countdown     = 0;
        exp_next      = RESET_PC;
        held_prev     = 1'b0;
        redirect_prev = 1'b0;
        prev_instr    = NOP;
        prev_pc       = RESET_PC;
        last_delivery = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (redirect_prev) begin
                checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_flush: cycle %0d got v=%b expected 0", cyc, instr_valid); end
            end
            if (instr_valid === 1'b1) begin
                if (held_prev) begin
                    checks++; if (instr !== prev_instr || pc !== prev_pc) begin errors++; $display("[TB] FAIL rnd_hold: cycle %0d got pc=%h instr=%h expected pc=%h instr=%h", cyc, pc, instr, prev_pc, prev_instr); end
                end else begin
                    checks++; if (pc !== exp_next) begin errors++; $display("[TB] FAIL rnd_pc: cycle %0d got %h expected %h", cyc, pc, exp_next); end
                    checks++; if (instr !== mem_word(pc)) begin errors++; $display("[TB] FAIL rnd_instr: cycle %0d got %h expected %h", cyc, instr, mem_word(pc)); end
                    exp_next      = pc + 32'd4;
                    last_delivery = cyc;
                end
            end else begin
                checks++; if (instr !== NOP) begin errors++; $display("[TB] FAIL rnd_nop: cycle %0d got %h expected %h", cyc, instr, NOP); end
            end

            stall         = ($urandom_range(2) == 0);
            pcbranch      = ($urandom_range(11) == 0);
            branch_target = $urandom;
            bus.imem_gnt  = ($urandom_range(2) != 0);
            if (pending && countdown == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(pend_addr);
                pending         = 1'b0;
            end else begin
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata  = $urandom;
                if (pending) countdown--;
            end
            settle();

            if (bus.imem_req === 1'b1 && bus.imem_gnt === 1'b1) begin
                checks++; if (pending) begin errors++; $display("[TB] FAIL rnd_outstanding: cycle %0d second request granted while %h outstanding", cyc, pend_addr); end
                checks++; if (bus.imem_addr !== exp_next) begin errors++; $display("[TB] FAIL rnd_fetch_addr: cycle %0d got %h expected %h", cyc, bus.imem_addr, exp_next); end
                pending   = 1'b1;
                pend_addr = bus.imem_addr;
                countdown = $urandom_range(2);
            end

            held_prev     = instr_valid && stall && !pcbranch;
            redirect_prev = pcbranch;
            prev_instr    = instr;
            prev_pc       = pc;
            if (pcbranch) exp_next = branch_target & 32'hFFFFFFFC;

            if (cyc - last_delivery > 100) begin
                checks++; errors++;
                $display("[TB] FAIL rnd_progress: no instruction delivered for %0d cycles, expected progress", cyc - last_delivery);
                break;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
